// File: rtl/mul_pkg.sv
// Shared definitions for the sequential 32x32 multiplier controller:
// state encoding, per-pass shift amounts and the pass-selection helpers.
package mul_pkg;

  localparam int HW_DEF  = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Shift amounts are in units of HW bits.
  localparam logic [1:0] SHIFT_P0 = 2'd0;
  localparam logic [1:0] SHIFT_P1 = 2'd1;
  localparam logic [1:0] SHIFT_P2 = 2'd1;
  localparam logic [1:0] SHIFT_P3 = 2'd2;

  // nz = {b_hi!=0, b_lo!=0, a_hi!=0, a_lo!=0}; result bit n means pass Pn runs.
  function automatic logic [3:0] pass_mask(input logic [3:0] nz, input bit skip_zero);
    logic [3:0] m;
    m[0] = nz[0] & nz[2];
    m[1] = nz[1] & nz[2];
    m[2] = nz[0] & nz[3];
    m[3] = nz[1] & nz[3];
    return skip_zero ? m : 4'hF;
  endfunction

  // Lowest-numbered pass at or after 'start' that runs, else DONE.
  function automatic state_e first_pass(input logic [3:0] run, input int start);
    state_e r;
    r = ST_DONE;
    for (int i = 3; i >= 0; i--) begin
      if (i >= start && run[i]) r = state_e'(3'(i + 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/mul32_acc.sv
// 4*HW-bit accumulator for the partial products: synchronous clear, or add
// of a zero-extended 2*HW addend shifted left by shift*HW bits.
module mul32_acc
  import mul_pkg::*;
#(
  parameter int HW = HW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            add_en,
  input  logic [2*HW-1:0] addend,
  input  logic [1:0]      shift,
  output logic [4*HW-1:0] acc
);

  logic [4*HW-1:0] ext;
  logic [4*HW-1:0] shifted;

  assign ext = {{(2*HW){1'b0}}, addend};

  always_comb begin
    shifted = ext;
    case (shift)
      2'd0:    shifted = ext;
      2'd1:    shifted = ext << HW;
      default: shifted = ext << (2*HW);
    endcase
  end

  // The full product fits in 4*HW bits, so the carry-out is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + shifted;
    end
  end

endmodule

// File: rtl/mul32_seq_ctrl.sv
// 32x32 unsigned multiply sequenced over an external 16x16 multiplier,
// one partial-product pass per cycle, zero-half passes optionally skipped.
module mul32_seq_ctrl
  import mul_pkg::*;
#(
  parameter int HW        = HW_DEF,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*HW-1:0]    in_a,
  input  logic [2*HW-1:0]    in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*HW-1:0]    out_p,
  output logic [HW-1:0]      mul_a,
  output logic [HW-1:0]      mul_b,
  input  logic [2*HW-1:0]    mul_p,
  output logic               busy,
  output logic [STATE_W-1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid and payload are held by the producer until then.

  state_e          state, state_nx;
  logic [2*HW-1:0] a_q, b_q;
  logic [4*HW-1:0] acc, out_q;
  logic [3:0]      run_in, run_q;
  logic            accept;
  logic            add_en;
  logic [1:0]      shift;

  assign run_in = pass_mask({|in_b[2*HW-1:HW], |in_b[HW-1:0],
                             |in_a[2*HW-1:HW], |in_a[HW-1:0]}, SKIP_ZERO);
  assign run_q  = pass_mask({|b_q[2*HW-1:HW], |b_q[HW-1:0],
                             |a_q[2*HW-1:HW], |a_q[HW-1:0]}, SKIP_ZERO);
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = first_pass(run_in, 0);
      ST_P0:   state_nx = first_pass(run_q, 1);
      ST_P1:   state_nx = first_pass(run_q, 2);
      ST_P2:   state_nx = first_pass(run_q, 3);
      ST_P3:   state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n & (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    mul_a     = '0;
    mul_b     = '0;
    add_en    = 1'b0;
    shift     = SHIFT_P0;
    case (state)
      ST_P0: begin
        mul_a = a_q[HW-1:0];    mul_b = b_q[HW-1:0];    add_en = 1'b1; shift = SHIFT_P0;
      end
      ST_P1: begin
        mul_a = a_q[2*HW-1:HW]; mul_b = b_q[HW-1:0];    add_en = 1'b1; shift = SHIFT_P1;
      end
      ST_P2: begin
        mul_a = a_q[HW-1:0];    mul_b = b_q[2*HW-1:HW]; add_en = 1'b1; shift = SHIFT_P2;
      end
      ST_P3: begin
        mul_a = a_q[2*HW-1:HW]; mul_b = b_q[2*HW-1:HW]; add_en = 1'b1; shift = SHIFT_P3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  // The accumulator is cleared on the next accept, so the delivered result
  // is copied out at the handshake to keep out_p stable afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            out_q <= '0;
    else if (state == ST_DONE && out_ready) out_q <= acc;
  end

  assign out_p     = out_valid ? acc : out_q;
  assign dbg_state = state;

  mul32_acc #(.HW(HW)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .add_en (add_en),
    .addend (mul_p),
    .shift  (shift),
    .acc    (acc)
  );

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Bench for mul32_seq_ctrl: directed vectors with literal expectations, a
// product scoreboard checked every cycle, and a random stall cross-check.
module tb_mul32_seq_ctrl;

  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]   in_a, in_b;
  logic [63:0]   out_p;
  logic [15:0]   mul_a, mul_b;
  logic [31:0]   mul_p;
  logic [2:0]    dbg_state;

  logic          in_valid_ns, in_ready_ns, out_valid_ns, out_ready_ns, busy_ns;
  logic [31:0]   in_a_ns, in_b_ns;
  logic [63:0]   out_p_ns;
  logic [15:0]   mul_a_ns, mul_b_ns;
  logic [31:0]   mul_p_ns;
  logic [2:0]    dbg_state_ns;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [63:0]   exp_q[$];
  bit            pending = 1'b0;
  bit            rand_ready = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  // external 16x16 multipliers
  assign mul_p    = 32'(mul_a) * 32'(mul_b);
  assign mul_p_ns = 32'(mul_a_ns) * 32'(mul_b_ns);

  mul32_seq_ctrl #(.HW(HW), .SKIP_ZERO(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy), .dbg_state(dbg_state)
  );

  mul32_seq_ctrl #(.HW(HW), .SKIP_ZERO(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_ns), .in_ready(in_ready_ns),
    .in_a(in_a_ns), .in_b(in_b_ns), .out_valid(out_valid_ns), .out_ready(out_ready_ns),
    .out_p(out_p_ns), .mul_a(mul_a_ns), .mul_b(mul_b_ns), .mul_p(mul_p_ns),
    .busy(busy_ns), .dbg_state(dbg_state_ns)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard: one job in flight at most, products delivered in order
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_p", out_p, 0);
      chk("rst_mul", {mul_a, mul_b}, 0);
      exp_q.delete();
      pending = 1'b0;
    end else begin
      chk("busy", busy, pending);
      chk("in_ready", in_ready, !pending);
      if (!busy || out_valid) chk("mul_idle", {mul_a, mul_b}, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_p", out_p, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pending = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(64'(in_a) * 64'(in_b));
        pending = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver: present a request and return one step after the accept edge
  task automatic submit(input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit chk_mul, input logic [15:0] ma, input logic [15:0] mb,
                            output int lat);
    bit got = 1'b0;
    lat = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
      if (chk_mul) begin
        chk("pass_mul_a", mul_a, ma);
        chk("pass_mul_b", mul_b, mb);
      end
      lat++;
    end
    if (!got) chk("valid_timeout", 0, 1);
  endtask

  task automatic job_ns(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_lat);
    bit got = 1'b0;
    int lat = 1;
    @(posedge clk); #1;
    in_a_ns = a; in_b_ns = b; in_valid_ns = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready_ns) begin got = 1'b1; break; end
    end
    if (!got) chk("ns_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid_ns = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_ns) begin got = 1'b1; break; end
      lat++;
    end
    if (!got) chk("ns_valid_timeout", 0, 1);
    chk("ns_latency", 64'(lat), 64'(exp_lat));
    chk("ns_out_p", out_p_ns, exp_p);
  endtask

  function automatic logic [15:0] rand_half();
    int r = $urandom_range(0, 7);
    if (r < 2) return 16'h0000;
    if (r == 2) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  initial begin
    int lat;
    bit drained;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    in_valid_ns = 0; in_a_ns = 0; in_b_ns = 0; out_ready_ns = 1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_p", out_p, 0);

    // four passes
    @(posedge clk); #1 out_ready = 1'b1;
    submit(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(1'b1, 16'hFFFF, 16'hFFFF, lat);
    chk("full_latency", 64'(lat), 5);
    chk("full_out_p", out_p, 64'hFFFFFFFE00000001);

    // skip paths: only P3, then only P0
    submit(32'h00010000, 32'h00010000);
    wait_valid(1'b1, 16'h0001, 16'h0001, lat);
    chk("p3_latency", 64'(lat), 2);
    chk("p3_out_p", out_p, 64'h0000000100000000);
    submit(32'h0000FFFF, 32'h0000FFFF);
    wait_valid(1'b1, 16'hFFFF, 16'hFFFF, lat);
    chk("p0_latency", 64'(lat), 2);
    chk("p0_out_p", out_p, 64'h00000000FFFE0001);

    // zero operand: no passes
    submit(32'h0, 32'h12345678);
    wait_valid(1'b1, 16'h0, 16'h0, lat);
    chk("zero_latency", 64'(lat), 1);
    chk("zero_out_p", out_p, 0);

    // all passes forced
    job_ns(32'h0, 32'h12345678, 64'h0, 5);
    job_ns(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 5);
    job_ns(32'h00010000, 32'h00010000, 64'h0000000100000000, 5);

    // backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    submit(32'h3, 32'h5);
    wait_valid(1'b1, 16'h3, 16'h5, lat);
    chk("bp_latency", 64'(lat), 2);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_p", out_p, 64'hF);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_in_ready", in_ready, 1);
    chk("bp_out_p_retained", out_p, 64'hF);

    // asynchronous reset during P1
    @(posedge clk); #1 out_ready = 1'b1;
    submit(32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_mul", {mul_a, mul_b}, 0);
    chk("abort_out_p", out_p, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    submit(32'h2, 32'h7);
    wait_valid(1'b1, 16'h2, 16'h7, lat);
    chk("after_reset_latency", 64'(lat), 2);
    chk("after_reset_out_p", out_p, 64'hE);

    // random operands with source and sink stalls
    rand_ready = 1'b1;
    for (int j = 0; j < 1000; j++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        in_a = $urandom; in_b = $urandom;
      end
      submit({rand_half(), rand_half()}, {rand_half(), rand_half()});
    end
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin drained = 1'b1; break; end
    end
    if (!drained) chk("drain_timeout", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
